// File: rtl/wr_arb_pkg.sv
// Shared types and the round-robin search helper for the QPI/HARP request arbiters.
package wr_arb_pkg;

  localparam int LINE_W  = 512;
  localparam int MAX_REQ = 8;

  typedef logic [1:0] wr_len_t;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int unsigned        n);
    rr_pick_t    res;
    int unsigned j;
    logic [2:0]  jj;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j  = (32'(ptr) + k) % n;
      jj = 3'(j);
      if (k < n && !res.found && req[jj]) begin
        res.found = 1'b1;
        res.idx   = jj;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wr_req_arbiter_if.sv
// Requester-side bundle plus the downstream write-channel drive of wr_req_arbiter.
interface wr_req_arbiter_if
  import wr_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_LMT = 20,
  parameter int TID_W    = 16
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_sop;
  logic [2*NUM_REQ-1:0]        req_len;
  logic [ADDR_LMT*NUM_REQ-1:0] req_addr;
  logic [LINE_W*NUM_REQ-1:0]   req_data;
  logic [TID_W*NUM_REQ-1:0]    req_tid;
  logic [NUM_REQ-1:0]          req_ready;

  logic                        WrAlmFull_in;
  logic                        WrEn_out;
  logic                        WrSop_out;
  logic [1:0]                  WrLen_out;
  logic [ADDR_LMT-1:0]         WrAddr_out;
  logic [LINE_W-1:0]           WrDin_out;
  logic [TID_W-1:0]            WrTID_out;

  modport master (
    output req_valid, req_sop, req_len, req_addr, req_data, req_tid, WrAlmFull_in,
    input  req_ready, WrEn_out, WrSop_out, WrLen_out, WrAddr_out, WrDin_out, WrTID_out
  );

  modport slave (
    input  req_valid, req_sop, req_len, req_addr, req_data, req_tid, WrAlmFull_in,
    output req_ready, WrEn_out, WrSop_out, WrLen_out, WrAddr_out, WrDin_out, WrTID_out
  );

endinterface

// File: rtl/wr_req_arbiter_rr_arb_core.sv
// Round-robin winner select with its rotating pointer; the pointer moves past the winner on update_en.
module rr_arb_core
  import wr_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update_en,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   ptr_next;
  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  assign req_ext = MAX_REQ'(req);

  always_comb begin
    pick   = rr_pick(req_ext, 3'(ptr_reg), NUM_REQ);
    found  = pick.found;
    winner = IDX_W'(pick.idx);
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (update_en) begin
      ptr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/wr_req_arbiter.sv
// Round-robin, burst-atomic arbiter onto the single write-request channel.
// Build option WR_ARB_PROTO_CHK_EN adds a sticky protocol checker (proto_err/err_id).
module wr_req_arbiter
  import wr_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int ADDR_LMT = 20,
  parameter  int TID_W    = 16,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic             Clk_400,
  input  logic             Resetb,
  wr_req_arbiter_if.slave  bus,
  output logic [IDX_W-1:0] grant_id,
  output logic             busy
`ifdef WR_ARB_PROTO_CHK_EN
  ,
  output logic             proto_err,
  output logic [IDX_W-1:0] err_id
`endif
);

  arb_state_e          state_reg, state_next;
  wr_len_t             beat_cnt_reg, beat_cnt_next;
  wr_len_t             len_reg, len_next;
  logic [IDX_W-1:0]    grant_reg, grant_next;

  wr_len_t             len_arr  [NUM_REQ];
  logic [ADDR_LMT-1:0] addr_arr [NUM_REQ];
  logic [LINE_W-1:0]   data_arr [NUM_REQ];
  logic [TID_W-1:0]    tid_arr  [NUM_REQ];

  logic [NUM_REQ-1:0]  cand;
  logic [NUM_REQ-1:0]  sel;
  logic [NUM_REQ-1:0]  ready;
  logic                found;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    sel_idx;
  logic                arb_take;
  logic                accept;
  logic                in_idle;

  logic                wr_en_reg;
  logic                wr_sop_reg;
  wr_len_t             wr_len_reg;
  logic [ADDR_LMT-1:0] wr_addr_reg;
  logic [LINE_W-1:0]   wr_din_reg;
  logic [TID_W-1:0]    wr_tid_reg;

  assign in_idle = (state_reg == ARB_IDLE);
  assign cand    = bus.req_valid & bus.req_sop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign len_arr[gi]  = bus.req_len[2*gi +: 2];
      assign addr_arr[gi] = bus.req_addr[ADDR_LMT*gi +: ADDR_LMT];
      assign data_arr[gi] = bus.req_data[LINE_W*gi +: LINE_W];
      assign tid_arr[gi]  = bus.req_tid[TID_W*gi +: TID_W];
      // In a burst only the owner is selectable, whatever else is requesting.
      assign sel[gi] = in_idle ? (found && (winner == IDX_W'(gi)))
                               : (grant_reg == IDX_W'(gi));
    end
  endgenerate

  rr_arb_core #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (Clk_400),
    .rst_n     (Resetb),
    .req       (cand),
    .update_en (arb_take),
    .found     (found),
    .winner    (winner)
  );

  assign ready         = sel & {NUM_REQ{~bus.WrAlmFull_in}};
  assign bus.req_ready = ready;
  assign accept        = |(bus.req_valid & ready);
  assign arb_take      = in_idle && found && !bus.WrAlmFull_in;
  assign sel_idx       = in_idle ? winner : grant_reg;

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    len_next      = len_reg;
    grant_next    = grant_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (arb_take) begin
          grant_next = winner;
          len_next   = len_arr[winner];
          if (len_arr[winner] != 2'd0) begin
            state_next    = ARB_BURST;
            beat_cnt_next = len_arr[winner];
          end
        end
      end
      ARB_BURST: begin
        if (accept) begin
          beat_cnt_next = beat_cnt_reg - 2'd1;
          if (beat_cnt_reg == 2'd1) begin
            state_next = ARB_IDLE;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk_400) begin
    if (!Resetb) begin
      state_reg    <= ARB_IDLE;
      beat_cnt_reg <= '0;
      len_reg      <= '0;
      grant_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      len_reg      <= len_next;
      grant_reg    <= grant_next;
    end
  end

  // Payload fields hold their last value when nothing is accepted.
  always_ff @(posedge Clk_400) begin
    if (!Resetb) begin
      wr_en_reg   <= 1'b0;
      wr_sop_reg  <= 1'b0;
      wr_len_reg  <= '0;
      wr_addr_reg <= '0;
      wr_din_reg  <= '0;
      wr_tid_reg  <= '0;
    end else begin
      wr_en_reg  <= accept;
      wr_sop_reg <= accept && in_idle;
      if (accept) begin
        wr_len_reg  <= len_next;
        wr_addr_reg <= addr_arr[sel_idx];
        wr_din_reg  <= data_arr[sel_idx];
        wr_tid_reg  <= tid_arr[sel_idx];
      end
    end
  end

  assign bus.WrEn_out   = wr_en_reg;
  assign bus.WrSop_out  = wr_sop_reg;
  assign bus.WrLen_out  = wr_len_reg;
  assign bus.WrAddr_out = wr_addr_reg;
  assign bus.WrDin_out  = wr_din_reg;
  assign bus.WrTID_out  = wr_tid_reg;
  assign grant_id       = grant_reg;
  assign busy           = (state_reg == ARB_BURST);

`ifdef WR_ARB_PROTO_CHK_EN
  logic             proto_err_reg;
  logic [IDX_W-1:0] err_id_reg;
  logic             bad_idle;
  logic             bad_burst;
  logic [IDX_W-1:0] bad_idle_idx;

  assign bad_idle  = in_idle && |(bus.req_valid & ~bus.req_sop);
  assign bad_burst = !in_idle && (|(bus.req_valid & bus.req_sop & sel));

  always_comb begin
    bad_idle_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && !bus.req_sop[i]) begin
        bad_idle_idx = IDX_W'(i);
      end
    end
  end

  // Only the first offender is recorded; the flag stays up until reset.
  always_ff @(posedge Clk_400) begin
    if (!Resetb) begin
      proto_err_reg <= 1'b0;
      err_id_reg    <= '0;
    end else if (!proto_err_reg && (bad_idle || bad_burst)) begin
      proto_err_reg <= 1'b1;
      err_id_reg    <= bad_burst ? grant_reg : bad_idle_idx;
    end
  end

  assign proto_err = proto_err_reg;
  assign err_id    = err_id_reg;
`endif

endmodule

// File: tb/tb_wr_req_arbiter.sv
// Table-driven bench for wr_req_arbiter with an output scoreboard; covers
// the WR_ARB_PROTO_CHK_EN checker when that macro is defined.
module tb_wr_req_arbiter;
  import wr_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int TW = 16;

  logic       clk = 1'b0;
  logic       resetb;
  logic [1:0] grant_id;
  logic       busy;
`ifdef WR_ARB_PROTO_CHK_EN
  logic       proto_err;
  logic [1:0] err_id;
`endif

  always #5 clk = ~clk;

  wr_req_arbiter_if #(.NUM_REQ(N), .ADDR_LMT(AW), .TID_W(TW)) bus ();

  wr_req_arbiter #(.NUM_REQ(N), .ADDR_LMT(AW), .TID_W(TW)) dut (
    .Clk_400  (clk),
    .Resetb   (resetb),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef WR_ARB_PROTO_CHK_EN
    ,
    .proto_err (proto_err),
    .err_id    (err_id)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] sop;
    logic [7:0] len;
    logic       full;
    logic [3:0] exp_ready;
    logic       exp_sop;
    logic [1:0] exp_len;
    logic       exp_busy;
    logic [1:0] exp_gid;
  } vec_t;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [LINE_W-1:0] data;
    logic [TW-1:0]     tid;
    logic              sop;
    logic [1:0]        len;
  } beat_t;

  beat_t         sb[$];
  vec_t          tbl[32];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] p_addr[N];
  logic [TW-1:0] p_tid[N];
  logic [23:0]   p_cnt[N];

  function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] s, logic [7:0] l, logic f,
                              logic [3:0] er, logic es, logic [1:0] el, logic eb, logic [1:0] eg);
    vec_t r;
    r.rst = rst; r.valid = v; r.sop = s; r.len = l; r.full = f;
    r.exp_ready = er; r.exp_sop = es; r.exp_len = el; r.exp_busy = eb; r.exp_gid = eg;
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] data_of(int i);
    logic [7:0] id;
    id = i[7:0];
    return {16{id, p_cnt[i]}};
  endfunction

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    resetb           = !v.rst;
    bus.WrAlmFull_in = v.full;
    bus.req_valid    = v.valid;
    bus.req_sop      = v.sop;
    bus.req_len      = v.len;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]         = p_addr[i];
      bus.req_data[i*LINE_W +: LINE_W] = data_of(i);
      bus.req_tid[i*TW +: TW]          = p_tid[i];
    end
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, " WrEn"},   bus.WrEn_out, 0);
    chk({tag, " WrSop"},  bus.WrSop_out, 0);
    chk({tag, " WrLen"},  bus.WrLen_out, 0);
    chk({tag, " WrAddr"}, bus.WrAddr_out, 0);
    chk({tag, " WrDin"},  bus.WrDin_out, 0);
    chk({tag, " WrTID"},  bus.WrTID_out, 0);
    chk({tag, " busy"},   busy, 0);
    chk({tag, " grant"},  grant_id, 0);
  endtask

  task automatic check_out(input bit after_rst, input int row);
    beat_t b;
    if (after_rst) begin
      check_zero_state($sformatf("row%0d reset", row));
    end else if (sb.size() > 0) begin
      b = sb.pop_front();
      chk($sformatf("row%0d WrEn", row),   bus.WrEn_out, 1);
      chk($sformatf("row%0d WrSop", row),  bus.WrSop_out, b.sop);
      chk($sformatf("row%0d WrLen", row),  bus.WrLen_out, b.len);
      chk($sformatf("row%0d WrAddr", row), bus.WrAddr_out, b.addr);
      chk($sformatf("row%0d WrDin", row),  bus.WrDin_out, b.data);
      chk($sformatf("row%0d WrTID", row),  bus.WrTID_out, b.tid);
    end else begin
      chk($sformatf("row%0d WrEn idle", row),  bus.WrEn_out, 0);
      chk($sformatf("row%0d WrSop idle", row), bus.WrSop_out, 0);
    end
  endtask

  task automatic do_reset();
    vec_t z;
    z = mk(1, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 2'd0);
    drive(z);
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    @(negedge clk);
    check_zero_state("reset");
    chk("reset req_ready", bus.req_ready, 0);
`ifdef WR_ARB_PROTO_CHK_EN
    chk("reset proto_err", proto_err, 0);
    chk("reset err_id", err_id, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit    prev_rst;
    beat_t b;

    for (int i = 0; i < N; i++) begin
      p_addr[i] = AW'(20'h10 * (i + 1));
      p_tid[i]  = TW'(16'h0100 * i + 16'h0001);
      p_cnt[i]  = 24'h0;
    end

    //            rst valid  sop    len    full rdy    sop len   busy gid
    // single requester, len=0
    tbl[0]  = mk(0, 4'h1, 4'h1, 8'h00, 0, 4'h1, 1, 2'd0, 0, 2'd0);
    tbl[1]  = mk(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 2'd0);
    // req1 four-beat burst; req2 SOP arrives during beat 2 and waits
    tbl[2]  = mk(0, 4'h2, 4'h2, 8'h0C, 0, 4'h2, 1, 2'd3, 0, 2'd0);
    tbl[3]  = mk(0, 4'h6, 4'h4, 8'h0C, 0, 4'h2, 0, 2'd3, 1, 2'd1);
    tbl[4]  = mk(0, 4'h6, 4'h4, 8'h0C, 0, 4'h2, 0, 2'd3, 1, 2'd1);
    tbl[5]  = mk(0, 4'h6, 4'h4, 8'h0C, 0, 4'h2, 0, 2'd3, 1, 2'd1);
    tbl[6]  = mk(0, 4'h4, 4'h4, 8'h00, 0, 4'h4, 1, 2'd0, 0, 2'd1);
    tbl[7]  = mk(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 2'd2);
    // fairness from reset: 0,1,2,3,0,1
    tbl[8]  = mk(1, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 2'd0);
    tbl[9]  = mk(0, 4'hF, 4'hF, 8'h00, 0, 4'h1, 1, 2'd0, 0, 2'd0);
    tbl[10] = mk(0, 4'hF, 4'hF, 8'h00, 0, 4'h2, 1, 2'd0, 0, 2'd0);
    tbl[11] = mk(0, 4'hF, 4'hF, 8'h00, 0, 4'h4, 1, 2'd0, 0, 2'd1);
    tbl[12] = mk(0, 4'hF, 4'hF, 8'h00, 0, 4'h8, 1, 2'd0, 0, 2'd2);
    tbl[13] = mk(0, 4'hF, 4'hF, 8'h00, 0, 4'h1, 1, 2'd0, 0, 2'd3);
    tbl[14] = mk(0, 4'hF, 4'hF, 8'h00, 0, 4'h2, 1, 2'd0, 0, 2'd0);
    tbl[15] = mk(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 2'd1);
    // backpressure: almost-full for 5 cycles after beat 1 of a req2 len=3 burst
    tbl[16] = mk(0, 4'h4, 4'h4, 8'h30, 0, 4'h4, 1, 2'd3, 0, 2'd1);
    tbl[17] = mk(0, 4'h4, 4'h0, 8'h30, 1, 4'h0, 0, 2'd3, 1, 2'd2);
    tbl[18] = mk(0, 4'h4, 4'h0, 8'h30, 1, 4'h0, 0, 2'd3, 1, 2'd2);
    tbl[19] = mk(0, 4'h4, 4'h0, 8'h30, 1, 4'h0, 0, 2'd3, 1, 2'd2);
    tbl[20] = mk(0, 4'h4, 4'h0, 8'h30, 1, 4'h0, 0, 2'd3, 1, 2'd2);
    tbl[21] = mk(0, 4'h4, 4'h0, 8'h30, 1, 4'h0, 0, 2'd3, 1, 2'd2);
    tbl[22] = mk(0, 4'h4, 4'h0, 8'h30, 0, 4'h4, 0, 2'd3, 1, 2'd2);
    tbl[23] = mk(0, 4'h4, 4'h0, 8'h30, 0, 4'h4, 0, 2'd3, 1, 2'd2);
    tbl[24] = mk(0, 4'h4, 4'h0, 8'h30, 0, 4'h4, 0, 2'd3, 1, 2'd2);
    tbl[25] = mk(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 2'd2);
    // reset after beat 2 of a req0 len=3 burst; req3 SOP wins afterwards
    tbl[26] = mk(0, 4'h1, 4'h1, 8'h03, 0, 4'h1, 1, 2'd3, 0, 2'd2);
    tbl[27] = mk(0, 4'h1, 4'h0, 8'h03, 0, 4'h1, 0, 2'd3, 1, 2'd0);
    tbl[28] = mk(1, 4'h1, 4'h0, 8'h03, 0, 4'h0, 0, 2'd0, 0, 2'd0);
    tbl[29] = mk(0, 4'h9, 4'h8, 8'h03, 0, 4'h8, 1, 2'd0, 0, 2'd0);
    tbl[30] = mk(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 2'd3);
    tbl[31] = mk(0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0, 2'd0, 0, 2'd3);

    do_reset();

    prev_rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      #1 drive(tbl[k]);
      @(negedge clk);
      check_out(prev_rst, k);
      if (tbl[k].rst) begin
        sb.delete();
      end else begin
        chk($sformatf("row%0d req_ready", k), bus.req_ready, tbl[k].exp_ready);
        chk($sformatf("row%0d busy", k), busy, tbl[k].exp_busy);
        chk($sformatf("row%0d grant_id", k), grant_id, tbl[k].exp_gid);
        for (int i = 0; i < N; i++) begin
          if (tbl[k].valid[i] && tbl[k].exp_ready[i]) begin
            b.addr = p_addr[i];
            b.data = data_of(i);
            b.tid  = p_tid[i];
            b.sop  = tbl[k].exp_sop;
            b.len  = tbl[k].exp_len;
            sb.push_back(b);
            $display("[TB] row %0d: req%0d beat accepted addr=%0h tid=%0h", k, i, b.addr, b.tid);
            p_addr[i] = p_addr[i] + 1'b1;
            p_tid[i]  = p_tid[i] + 1'b1;
            p_cnt[i]  = p_cnt[i] + 1'b1;
          end
        end
      end
      prev_rst = tbl[k].rst;
    end
    chk("scoreboard drained", sb.size(), 0);

    // Valid without SOP in IDLE: never granted; the checker flags the first offender only.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      bus.req_valid = (c >= 2) ? 4'h5 : 4'h4;
      bus.req_sop   = 4'h0;
      @(negedge clk);
      chk($sformatf("nosop c%0d req_ready", c), bus.req_ready, 0);
      chk($sformatf("nosop c%0d WrEn", c), bus.WrEn_out, 0);
`ifdef WR_ARB_PROTO_CHK_EN
      chk($sformatf("nosop c%0d proto_err", c), proto_err, (c >= 1) ? 1 : 0);
      chk($sformatf("nosop c%0d err_id", c), err_id, (c >= 1) ? 2 : 0);
`endif
      $display("[TB] nosop cycle %0d: valid=%0h ready=%0h", c, bus.req_valid, bus.req_ready);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
